// File: rtl/writeback_stage_if.sv
// Writeback stage bus: upstream handshake, data-memory return path and
// register-file write port. master drives the stage, slave is the stage.
interface writeback_stage_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  In_Rd;
  logic        In_Reg_Write;
  logic        In_Is_Load;
  logic [31:0] In_Alu_Result;
  logic [2:0]  In_Funct3;
  logic [1:0]  In_Addr_Low;
  logic        Mem_Rdata_Valid;
  logic [31:0] Mem_Rdata;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic        Sig_Reg_Write;
  logic        Load_Err;
  logic [31:0] Retire_Count;

  modport master (
    output In_Valid, In_Rd, In_Reg_Write, In_Is_Load, In_Alu_Result, In_Funct3, In_Addr_Low,
    output Mem_Rdata_Valid, Mem_Rdata,
    input  In_Ready, Write_Register, Write_Data, Sig_Reg_Write, Load_Err, Retire_Count
  );

  modport slave (
    input  In_Valid, In_Rd, In_Reg_Write, In_Is_Load, In_Alu_Result, In_Funct3, In_Addr_Low,
    input  Mem_Rdata_Valid, Mem_Rdata,
    output In_Ready, Write_Register, Write_Data, Sig_Reg_Write, Load_Err, Retire_Count
  );
endinterface

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: commits ALU results in one cycle, waits for load
// data with a bounded timeout, and counts retired instructions.
// Optional feature macro: WB_SUBWORD_EN (byte/halfword load extraction and
// sign/zero extension). Without it every load writes the memory word as-is.
module writeback_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              reset_n,
  writeback_stage_if.slave io_wb
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWaitLoad, StCommit} state_e;

  state_e        r_state;
  logic [CntW-1:0] r_cnt;
  logic [4:0]    r_ld_rd;
  logic          r_ld_reg_write;
  logic [4:0]    r_wr_reg;
  logic [31:0]   r_wr_data;
  logic          r_sig_reg_write;
  logic          r_load_err;
  logic [31:0]   r_retire;
  logic [31:0]   w_load_data;
  logic          w_timeout;

`ifdef WB_SUBWORD_EN
  logic [2:0]    r_ld_funct3;
  logic [1:0]    r_ld_addr_low;

  // Little-endian lane select; halfwords use addr bit 1 only.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {addr, 3'b000});
    h = 16'(word >> {addr[1], 4'b0000});
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Extended load data for the captured load type and lane.
  always_comb begin
    w_load_data = extend_load(io_wb.Mem_Rdata, r_ld_funct3, r_ld_addr_low);
  end

  // Load type and lane are captured at the transfer into WAIT_LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_funct3   <= 3'd0;
      r_ld_addr_low <= 2'd0;
    end else if (r_state != StWaitLoad && io_wb.In_Valid && io_wb.In_Is_Load) begin
      r_ld_funct3   <= io_wb.In_Funct3;
      r_ld_addr_low <= io_wb.In_Addr_Low;
    end
  end
`else
  logic w_unused_subword;

  // Word loads only; load type and lane are don't-care.
  always_comb begin
    w_load_data      = io_wb.Mem_Rdata;
    w_unused_subword = ^{io_wb.In_Funct3, io_wb.In_Addr_Low};
  end
`endif

  // Last permitted wait edge: data arriving on this edge still wins.
  always_comb begin
    w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
  end

  // Stage FSM with registered write port, error pulse and retire counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_ld_rd         <= 5'd0;
      r_ld_reg_write  <= 1'b0;
      r_wr_reg        <= 5'd0;
      r_wr_data       <= 32'd0;
      r_sig_reg_write <= 1'b0;
      r_load_err      <= 1'b0;
      r_retire        <= 32'd0;
    end else begin
      r_sig_reg_write <= 1'b0;
      r_load_err      <= 1'b0;
      case (r_state)
        StIdle, StCommit: begin
          if (io_wb.In_Valid) begin
            if (!io_wb.In_Is_Load) begin
              r_state         <= StCommit;
              r_wr_reg        <= io_wb.In_Rd;
              r_wr_data       <= io_wb.In_Alu_Result;
              r_sig_reg_write <= io_wb.In_Reg_Write && (io_wb.In_Rd != 5'd0);
              r_retire        <= r_retire + 32'd1;
            end else begin
              r_state        <= StWaitLoad;
              r_cnt          <= '0;
              r_ld_rd        <= io_wb.In_Rd;
              r_ld_reg_write <= io_wb.In_Reg_Write;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StWaitLoad: begin
          if (io_wb.Mem_Rdata_Valid) begin
            r_state         <= StCommit;
            r_wr_reg        <= r_ld_rd;
            r_wr_data       <= w_load_data;
            r_sig_reg_write <= r_ld_reg_write && (r_ld_rd != 5'd0);
            r_retire        <= r_retire + 32'd1;
          end else if (w_timeout) begin
            r_state    <= StIdle;
            r_load_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_wb.In_Ready       = (r_state != StWaitLoad);
  assign io_wb.Write_Register = r_wr_reg;
  assign io_wb.Write_Data     = r_wr_data;
  assign io_wb.Sig_Reg_Write  = r_sig_reg_write;
  assign io_wb.Load_Err       = r_load_err;
  assign io_wb.Retire_Count   = r_retire;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_writeback_stage;

  localparam int unsigned Timeout = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  writeback_stage_if bus ();

  writeback_stage #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_wb   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [1:0]  addr;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Picks the expected value for the configured load behaviour.
  function automatic logic [31:0] sel(input logic [31:0] sub, input logic [31:0] word);
`ifdef WB_SUBWORD_EN
    return sub;
`else
    return word;
`endif
  endfunction

  // Reference load extension from plain arithmetic on the memory word.
  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] a);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * a)) % 256;
    h = (w >> (16 * (a / 2))) % 65536;
`ifdef WB_SUBWORD_EN
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
`else
    return (b + h + 32'(f3) == 0) ? w : w;
`endif
  endfunction

  task automatic idle_inputs();
    bus.In_Valid = 1'b0; bus.In_Rd = 5'd0; bus.In_Reg_Write = 1'b0; bus.In_Is_Load = 1'b0;
    bus.In_Alu_Result = 32'd0; bus.In_Funct3 = 3'd0; bus.In_Addr_Low = 2'd0;
    bus.Mem_Rdata_Valid = 1'b0; bus.Mem_Rdata = 32'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.Sig_Reg_Write), 0);
    check("rst_err", 32'(bus.Load_Err), 0);
    check("rst_wreg", 32'(bus.Write_Register), 0);
    check("rst_wdata", bus.Write_Data, 0);
    check("rst_cnt", bus.Retire_Count, 0);
    reset_n = 1'b1;
    exp_cnt = 32'd0;
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.In_Ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bus.In_Valid = 1'b1; bus.In_Is_Load = v.is_load; bus.In_Rd = v.rd;
    bus.In_Reg_Write = v.we; bus.In_Alu_Result = v.alu; bus.In_Funct3 = v.f3;
    bus.In_Addr_Low = v.addr;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    if (v.is_load) begin
      check({tag, "_ready_low"}, 32'(bus.In_Ready), 0);
      repeat (v.waits) begin @(posedge clk); #1; end
      bus.Mem_Rdata_Valid = 1'b1; bus.Mem_Rdata = v.rdata;
      @(posedge clk); #1;
      bus.Mem_Rdata_Valid = 1'b0;
    end
    exp_cnt++;
    check({tag, "_we"}, 32'(bus.Sig_Reg_Write), 32'(v.exp_we));
    check({tag, "_wreg"}, 32'(bus.Write_Register), 32'(v.rd));
    check({tag, "_wdata"}, bus.Write_Data, v.exp_data);
    check({tag, "_cnt"}, bus.Retire_Count, exp_cnt);
    @(posedge clk); #1;
    check({tag, "_we_pulse"}, 32'(bus.Sig_Reg_Write), 0);
    check({tag, "_hold"}, bus.Write_Data, v.exp_data);
  endtask

  // Model state: one outstanding load at most, plus the visible write port.
  logic        m_loading;
  int          m_waited;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;
  logic        e_we, e_err;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic m_commit(input logic [4:0] rd, input logic we, input logic [31:0] d);
    e_rd = rd; e_data = d; e_we = we && (rd != 0); exp_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [4:0] rds[4];
    logic [31:0] hold;

    vecs[0] = '{1'b0, 5'd5, 1'b1, 32'h12345678, 3'd0, 2'd0, 32'd0, 0, 32'h12345678, 1'b1};
    vecs[1] = '{1'b0, 5'd0, 1'b1, 32'hDEADBEEF, 3'd0, 2'd0, 32'd0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 5'd31, 1'b0, 32'h00000001, 3'd0, 2'd0, 32'd0, 0, 32'h00000001, 1'b0};
    vecs[3] = '{1'b1, 5'd7, 1'b1, 32'd0, 3'b000, 2'd2, 32'h00800000, 3,
                sel(32'hFFFFFF80, 32'h00800000), 1'b1};
    vecs[4] = '{1'b1, 5'd8, 1'b1, 32'd0, 3'b100, 2'd2, 32'h00800000, 1,
                sel(32'h00000080, 32'h00800000), 1'b1};
    vecs[5] = '{1'b1, 5'd9, 1'b1, 32'd0, 3'b001, 2'd2, 32'h80010000, 0,
                sel(32'hFFFF8001, 32'h80010000), 1'b1};
    vecs[6] = '{1'b1, 5'd10, 1'b1, 32'd0, 3'b101, 2'd0, 32'h1234F00D, 2,
                sel(32'h0000F00D, 32'h1234F00D), 1'b1};
    vecs[7] = '{1'b1, 5'd11, 1'b1, 32'd0, 3'b010, 2'd1, 32'hCAFEBABE, 1, 32'hCAFEBABE, 1'b1};
    vecs[8] = '{1'b1, 5'd12, 1'b1, 32'd0, 3'b011, 2'd3, 32'h11223344, 0, 32'h11223344, 1'b1};
    vecs[9] = '{1'b1, 5'd0, 1'b1, 32'd0, 3'b000, 2'd3, 32'h7F000000, 2,
                sel(32'h0000007F, 32'h7F000000), 1'b0};

    do_reset();
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Four back-to-back ALU ops, one aimed at x0.
    do_reset();
    rds[0] = 5'd3; rds[1] = 5'd0; rds[2] = 5'd4; rds[3] = 5'd6;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus.In_Valid = 1'b1; bus.In_Is_Load = 1'b0; bus.In_Reg_Write = 1'b1;
      bus.In_Rd = rds[i]; bus.In_Alu_Result = 32'(i * 16 + 1);
      @(posedge clk); #1;
      check($sformatf("x0_ready%0d", i), 32'(bus.In_Ready), 1);
      pulses += int'(bus.Sig_Reg_Write);
    end
    bus.In_Valid = 1'b0;
    check("x0_pulses", 32'(pulses), 3);
    check("x0_cnt", bus.Retire_Count, 4);
    check("x0_wdata", bus.Write_Data, 32'd49);
    exp_cnt = 32'd4;
    @(posedge clk); #1;

    // Load never answered: abandoned after Timeout wait edges.
    hold = bus.Write_Data;
    bus.In_Valid = 1'b1; bus.In_Is_Load = 1'b1; bus.In_Rd = 5'd9; bus.In_Reg_Write = 1'b1;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    for (int i = 0; i < int'(Timeout) - 1; i++) begin
      @(posedge clk); #1;
      check($sformatf("to_noerr%0d", i), 32'(bus.Load_Err), 0);
    end
    @(posedge clk); #1;
    check("to_err", 32'(bus.Load_Err), 1);
    check("to_we", 32'(bus.Sig_Reg_Write), 0);
    check("to_ready", 32'(bus.In_Ready), 1);
    check("to_cnt", bus.Retire_Count, exp_cnt);
    @(posedge clk); #1;
    check("to_err_pulse", 32'(bus.Load_Err), 0);

    // Memory data outside WAIT_LOAD must be ignored.
    bus.Mem_Rdata_Valid = 1'b1; bus.Mem_Rdata = 32'hA5A5A5A5;
    repeat (2) begin @(posedge clk); #1; end
    bus.Mem_Rdata_Valid = 1'b0;
    check("ign_we", 32'(bus.Sig_Reg_Write), 0);
    check("ign_cnt", bus.Retire_Count, exp_cnt);
    check("ign_wdata", bus.Write_Data, hold);

    // Reset in WAIT_LOAD, then late memory data.
    bus.In_Valid = 1'b1; bus.In_Is_Load = 1'b1; bus.In_Rd = 5'd14; bus.In_Reg_Write = 1'b1;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_cnt", bus.Retire_Count, 0);
    check("arst_wdata", bus.Write_Data, 0);
    check("arst_ready", 32'(bus.In_Ready), 1);
    @(posedge clk); #2;
    reset_n = 1'b1;
    bus.Mem_Rdata_Valid = 1'b1; bus.Mem_Rdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("arst_we%0d", i), 32'(bus.Sig_Reg_Write), 0);
    end
    bus.Mem_Rdata_Valid = 1'b0;
    check("arst_cnt2", bus.Retire_Count, 0);
    check("arst_ready2", 32'(bus.In_Ready), 1);

    // Randomized traffic against the transaction model.
    do_reset();
    m_loading = 1'b0; m_waited = 0; m_rd = 5'd0; m_we = 1'b0; m_f3 = 3'd0; m_a = 2'd0;
    e_we = 1'b0; e_err = 1'b0; e_rd = 5'd0; e_data = 32'd0;
    for (int n = 0; n < 400; n++) begin
      bus.In_Valid = ($urandom_range(0, 3) != 0);
      bus.In_Is_Load = ($urandom_range(0, 2) == 0);
      bus.In_Rd = 5'($urandom_range(0, 31));
      bus.In_Reg_Write = 1'($urandom);
      bus.In_Alu_Result = $urandom;
      bus.In_Funct3 = 3'($urandom);
      bus.In_Addr_Low = 2'($urandom);
      bus.Mem_Rdata_Valid = ($urandom_range(0, 5) == 0);
      bus.Mem_Rdata = $urandom;
      check("rnd_ready", 32'(bus.In_Ready), 32'(!m_loading));
      e_we = 1'b0; e_err = 1'b0;
      if (m_loading) begin
        if (bus.Mem_Rdata_Valid) begin
          m_commit(m_rd, m_we, m_ext(bus.Mem_Rdata, m_f3, m_a));
          m_loading = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == int'(Timeout)) begin
            e_err = 1'b1;
            m_loading = 1'b0;
          end
        end
      end else if (bus.In_Valid) begin
        if (!bus.In_Is_Load) begin
          m_commit(bus.In_Rd, bus.In_Reg_Write, bus.In_Alu_Result);
        end else begin
          m_loading = 1'b1; m_waited = 0; m_rd = bus.In_Rd; m_we = bus.In_Reg_Write;
          m_f3 = bus.In_Funct3; m_a = bus.In_Addr_Low;
        end
      end
      @(posedge clk); #1;
      check("rnd_we", 32'(bus.Sig_Reg_Write), 32'(e_we));
      check("rnd_err", 32'(bus.Load_Err), 32'(e_err));
      check("rnd_cnt", bus.Retire_Count, exp_cnt);
      check("rnd_wreg", 32'(bus.Write_Register), 32'(e_rd));
      check("rnd_wdata", bus.Write_Data, e_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
